// File: rtl/cache_pkg.sv
// Shared types and sizing for the set-associative cache set.
package cache_pkg;

  localparam int unsigned TAG_WIDTH    = 8;
  localparam int unsigned OFFSET_WIDTH = 4;
  localparam int unsigned WAYS         = 2;

  localparam int unsigned WORD_W    = OFFSET_WIDTH - 2;
  localparam int unsigned LINE_SIZE = 1 << WORD_W;
  localparam int unsigned WAY_W     = $clog2(WAYS);

  typedef logic [WAY_W-1:0]     way_idx_t;
  typedef logic [WAY_W-1:0]     age_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [WORD_W-1:0]    word_idx_t;

  typedef enum logic {IDLE, REFILL} set_state_t;

endpackage

// File: rtl/cache_set_if.sv
// Controller-facing bus of one cache set; stats ports exist only with CACHE_SET_STATS_EN.
interface cache_set_if;
  import cache_pkg::*;

  logic        lookup_i;
  tag_t        tag_i;
  word_idx_t   offset_i;
  logic        write_en_i;
  logic [3:0]  byte_en_i;
  logic [31:0] write_data_i;
  logic        hit_o;
  way_idx_t    hit_way_o;
  logic [31:0] read_data_o;
  way_idx_t    victim_way_o;
  logic        victim_valid_o;
  logic        victim_dirty_o;
  tag_t        victim_tag_o;
  logic [31:0] victim_data_o;
  logic        refill_start_i;
  logic        refill_valid_i;
  logic [31:0] refill_data_i;
  logic        busy_o;
  logic        refill_done_o;
`ifdef CACHE_SET_STATS_EN
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;
`endif

  modport master (
    output lookup_i, tag_i, offset_i, write_en_i, byte_en_i, write_data_i,
    output refill_start_i, refill_valid_i, refill_data_i,
`ifdef CACHE_SET_STATS_EN
    input  hit_count_o, miss_count_o,
`endif
    input  hit_o, hit_way_o, read_data_o, victim_way_o, victim_valid_o,
    input  victim_dirty_o, victim_tag_o, victim_data_o, busy_o, refill_done_o
  );

  modport slave (
    input  lookup_i, tag_i, offset_i, write_en_i, byte_en_i, write_data_i,
    input  refill_start_i, refill_valid_i, refill_data_i,
`ifdef CACHE_SET_STATS_EN
    output hit_count_o, miss_count_o,
`endif
    output hit_o, hit_way_o, read_data_o, victim_way_o, victim_valid_o,
    output victim_dirty_o, victim_tag_o, victim_data_o, busy_o, refill_done_o
  );

endinterface

// File: rtl/cache_way.sv
// One way of the set: valid/dirty/tag/line storage with store, refill and flag update ports.
module cache_way
  import cache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  tag_t        lookup_tag_i,
  input  word_idx_t   offset_i,
  input  logic        store_en_i,
  input  logic [3:0]  byte_en_i,
  input  logic [31:0] store_data_i,
  input  logic        fill_en_i,
  input  word_idx_t   fill_idx_i,
  input  logic [31:0] fill_data_i,
  input  logic        clear_i,
  input  logic        complete_i,
  input  tag_t        fill_tag_i,
  output logic        valid_o,
  output logic        dirty_o,
  output tag_t        tag_o,
  output logic        match_o,
  output logic [31:0] rd_data_o
);

  logic                       valid_q, valid_d;
  logic                       dirty_q, dirty_d;
  tag_t                       tag_q, tag_d;
  logic [LINE_SIZE-1:0][31:0] data_q, data_d;

  // Later assignments win: a clear overrides a same-edge store's dirty set.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (store_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_i[b]) data_d[offset_i][8*b +: 8] = store_data_i[8*b +: 8];
      end
      dirty_d = 1'b1;
    end
    if (fill_en_i) data_d[fill_idx_i] = fill_data_i;
    if (clear_i) begin
      valid_d = 1'b0;
      dirty_d = 1'b0;
    end
    if (complete_i) begin
      valid_d = 1'b1;
      dirty_d = 1'b0;
      tag_d   = fill_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign dirty_o   = dirty_q;
  assign tag_o     = tag_q;
  assign match_o   = valid_q && (tag_q == lookup_tag_i);
  assign rd_data_o = data_q[offset_i];

endmodule

// File: rtl/cache_set.sv
// N-way cache set: way storage, age-based LRU, victim choice and burst refill FSM.
// Optional hit/miss counters are built when CACHE_SET_STATS_EN is defined.
module cache_set
  import cache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  cache_set_if.slave  bus
);

  set_state_t           state_q, state_d;
  way_idx_t             fill_way_q, fill_way_d;
  tag_t                 fill_tag_q, fill_tag_d;
  word_idx_t            cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  age_t [WAYS-1:0]      age_q, age_d;

  logic [WAYS-1:0]      way_valid, way_dirty, way_match;
  tag_t                 way_tag [WAYS];
  logic [31:0]          way_rd  [WAYS];
  logic [WAYS-1:0]      store_sel, fill_sel, clear_sel, complete_sel;

  logic                 hit_any, hit_c, inv_found, touch_en;
  way_idx_t             hit_way, victim_way, touch_way;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way u_way (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .lookup_tag_i (bus.tag_i),
      .offset_i     (bus.offset_i),
      .store_en_i   (store_sel[w]),
      .byte_en_i    (bus.byte_en_i),
      .store_data_i (bus.write_data_i),
      .fill_en_i    (fill_sel[w]),
      .fill_idx_i   (cnt_q),
      .fill_data_i  (bus.refill_data_i),
      .clear_i      (clear_sel[w]),
      .complete_i   (complete_sel[w]),
      .fill_tag_i   (fill_tag_q),
      .valid_o      (way_valid[w]),
      .dirty_o      (way_dirty[w]),
      .tag_o        (way_tag[w]),
      .match_o      (way_match[w]),
      .rd_data_o    (way_rd[w])
    );
  end

  // Lowest-index matching way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        hit_any = 1'b1;
        hit_way = way_idx_t'(w);
      end
    end
  end

  assign hit_c = hit_any && (state_q == IDLE);

  // Prefer the lowest invalid way, else the oldest.
  always_comb begin
    inv_found  = 1'b0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        inv_found  = 1'b1;
        victim_way = way_idx_t'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w] == age_t'(WAYS - 1)) victim_way = way_idx_t'(w);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_way_d   = fill_way_q;
    fill_tag_d   = fill_tag_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    store_sel    = '0;
    fill_sel     = '0;
    clear_sel    = '0;
    complete_sel = '0;
    touch_en     = 1'b0;
    touch_way    = hit_way;
    case (state_q)
      IDLE: begin
        if (bus.write_en_i && hit_c) store_sel[hit_way] = 1'b1;
        if (bus.lookup_i && hit_c)   touch_en = 1'b1;
        if (bus.refill_start_i) begin
          state_d               = REFILL;
          fill_way_d            = victim_way;
          fill_tag_d            = bus.tag_i;
          cnt_d                 = '0;
          clear_sel[victim_way] = 1'b1;
        end
      end
      REFILL: begin
        if (bus.refill_valid_i) begin
          fill_sel[fill_way_q] = 1'b1;
          cnt_d                = cnt_q + 1'b1;
          if (cnt_q == word_idx_t'(LINE_SIZE - 1)) begin
            complete_sel[fill_way_q] = 1'b1;
            touch_en                 = 1'b1;
            touch_way                = fill_way_q;
            done_d                   = 1'b1;
            cnt_d                    = '0;
            state_d                  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == REFILL);
  end

  // Touched way becomes youngest; younger ways age by one.
  always_comb begin
    age_d = age_q;
    if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (way_idx_t'(w) == touch_way)        age_d[w] = '0;
        else if (age_q[w] < age_q[touch_way]) age_d[w] = age_q[w] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fill_way_q <= '0;
      fill_tag_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int w = 0; w < WAYS; w++) age_q[w] <= age_t'(w);
    end else begin
      state_q    <= state_d;
      fill_way_q <= fill_way_d;
      fill_tag_q <= fill_tag_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      age_q      <= age_d;
    end
  end

  assign bus.hit_o          = hit_c;
  assign bus.hit_way_o      = hit_c ? hit_way : '0;
  assign bus.read_data_o    = hit_c ? way_rd[hit_way] : 32'd0;
  assign bus.victim_way_o   = victim_way;
  assign bus.victim_valid_o = way_valid[victim_way];
  assign bus.victim_dirty_o = way_dirty[victim_way];
  assign bus.victim_tag_o   = way_tag[victim_way];
  assign bus.victim_data_o  = way_rd[victim_way];
  assign bus.busy_o         = busy_q;
  assign bus.refill_done_o  = done_q;

`ifdef CACHE_SET_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating access counters; lookups during refill are not misses.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.lookup_i && hit_c && (hit_cnt_q != 32'hFFFF_FFFF))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (bus.lookup_i && !hit_c && (state_q == IDLE) && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count_o  = hit_cnt_q;
  assign bus.miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_set.sv
// Bench for cache_set: directed scenarios plus random traffic against a queue-based LRU model.
module tb_cache_set;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_set_if bus();
  cache_set dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-way contents and a recency list (front = most recent).
  bit          m_valid [WAYS];
  bit          m_dirty [WAYS];
  tag_t        m_tag   [WAYS];
  logic [31:0] m_data  [WAYS][LINE_SIZE];
  int          m_lru[$];
  bit          m_refilling;
  int          m_fw;
  tag_t        m_ftag;
  int          m_got;
  bit          m_done;

  function automatic void model_reset();
    m_lru = {};
    for (int w = 0; w < WAYS; w++) begin
      m_valid[w] = 0;
      m_dirty[w] = 0;
      m_tag[w]   = '0;
      for (int i = 0; i < LINE_SIZE; i++) m_data[w][i] = 32'd0;
      m_lru.push_back(w);
    end
    m_refilling = 0;
    m_got       = 0;
    m_done      = 0;
  endfunction

  function automatic int model_hit();
    if (m_refilling) return -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w] && m_tag[w] == bus.tag_i) return w;
    return -1;
  endfunction

  function automatic int model_victim();
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[w]) return w;
    return m_lru[$];
  endfunction

  function automatic void model_touch(int w);
    int idx;
    idx = -1;
    for (int i = 0; i < m_lru.size(); i++) if (m_lru[i] == w) idx = i;
    if (idx >= 0) m_lru.delete(idx);
    m_lru.push_front(w);
  endfunction

  task automatic drive_idle();
    bus.lookup_i       = 1'b0;
    bus.tag_i          = '0;
    bus.offset_i       = '0;
    bus.write_en_i     = 1'b0;
    bus.byte_en_i      = 4'h0;
    bus.write_data_i   = 32'd0;
    bus.refill_start_i = 1'b0;
    bus.refill_valid_i = 1'b0;
    bus.refill_data_i  = 32'd0;
  endtask

  // Advance the model by the effect of the currently driven inputs, then clock.
  task automatic cycle();
    int h, v, tw;
    bit do_touch;
    h = model_hit();
    v = model_victim();
    do_touch = 0;
    tw = 0;
    m_done = 0;
    if (!m_refilling) begin
      if (bus.lookup_i && h >= 0) begin
        do_touch = 1;
        tw = h;
      end
      if (bus.write_en_i && h >= 0) begin
        for (int b = 0; b < 4; b++)
          if (bus.byte_en_i[b]) m_data[h][bus.offset_i][8*b +: 8] = bus.write_data_i[8*b +: 8];
        m_dirty[h] = 1;
      end
      if (bus.refill_start_i) begin
        m_fw = v;
        m_ftag = bus.tag_i;
        m_valid[v] = 0;
        m_dirty[v] = 0;
        m_got = 0;
        m_refilling = 1;
      end
    end else if (bus.refill_valid_i) begin
      m_data[m_fw][m_got] = bus.refill_data_i;
      m_got++;
      if (m_got == LINE_SIZE) begin
        m_valid[m_fw] = 1;
        m_dirty[m_fw] = 0;
        m_tag[m_fw]   = m_ftag;
        do_touch = 1;
        tw = m_fw;
        m_refilling = 0;
        m_done = 1;
      end
    end
    if (do_touch) model_touch(tw);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    bus.lookup_i = 1'b1;
    bus.tag_i    = tag_t'(8'h12);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (bus.hit_o !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %0h want 0", bus.hit_o); end
    n_cmp++; if (bus.victim_way_o !== way_idx_t'(0)) begin n_err++; $display("FAIL reset_victim_way: got %0h want 0", bus.victim_way_o); end
    n_cmp++; if (bus.victim_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_victim_valid: got %0h want 0", bus.victim_valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", bus.busy_o); end
    n_cmp++; if (bus.refill_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0h want 0", bus.refill_done_o); end
    rst_n = 1'b1;
    model_reset();
    drive_idle();
    cycle();
  endtask

  task automatic test_refill();
    drive_idle();
    bus.tag_i = tag_t'(8'h12);
    bus.refill_start_i = 1'b1;
    cycle();
    bus.refill_start_i = 1'b0;
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL refill_busy_start: got %0h want 1", bus.busy_o); end
    for (int i = 0; i < LINE_SIZE; i++) begin
      if (i == 1) begin
        bus.refill_valid_i = 1'b0;
        cycle();
        n_cmp++; if (bus.busy_o !== 1'b1 || bus.refill_done_o !== 1'b0) begin n_err++; $display("FAIL refill_gap: busy %0h done %0h want 1 0", bus.busy_o, bus.refill_done_o); end
      end
      bus.refill_valid_i = 1'b1;
      bus.refill_data_i  = 32'hA0 + 32'(i);
      cycle();
      if (i < LINE_SIZE - 1) begin
        n_cmp++; if (bus.busy_o !== 1'b1 || bus.refill_done_o !== 1'b0) begin n_err++; $display("FAIL refill_word%0d: busy %0h done %0h want 1 0", i, bus.busy_o, bus.refill_done_o); end
      end else begin
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.refill_done_o !== 1'b1) begin n_err++; $display("FAIL refill_last: busy %0h done %0h want 0 1", bus.busy_o, bus.refill_done_o); end
      end
    end
    bus.refill_valid_i = 1'b0;
    cycle();
    n_cmp++; if (bus.refill_done_o !== 1'b0) begin n_err++; $display("FAIL refill_done_pulse: got %0h want 0", bus.refill_done_o); end
    bus.lookup_i = 1'b1;
    bus.offset_i = word_idx_t'(2);
    #1;
    n_cmp++; if (bus.hit_o !== 1'b1) begin n_err++; $display("FAIL refill_hit: got %0h want 1", bus.hit_o); end
    n_cmp++; if (bus.read_data_o !== 32'hA2) begin n_err++; $display("FAIL refill_read: got %08h want 000000a2", bus.read_data_o); end
    n_cmp++; if (bus.hit_way_o !== way_idx_t'(0)) begin n_err++; $display("FAIL refill_way: got %0h want 0", bus.hit_way_o); end
    cycle();
    drive_idle();
  endtask

  task automatic test_store();
    drive_idle();
    bus.tag_i        = tag_t'(8'h12);
    bus.offset_i     = word_idx_t'(1);
    bus.write_en_i   = 1'b1;
    bus.byte_en_i    = 4'b0011;
    bus.write_data_i = 32'hDEADBEEF;
    cycle();
    bus.write_en_i = 1'b0;
    bus.lookup_i   = 1'b1;
    #1;
    n_cmp++; if (bus.read_data_o !== 32'h0000BEEF) begin n_err++; $display("FAIL store_read: got %08h want 0000beef", bus.read_data_o); end
    bus.tag_i = tag_t'(8'h99);
    bus.write_en_i = 1'b1;
    #1;
    n_cmp++; if (bus.hit_o !== 1'b0) begin n_err++; $display("FAIL store_miss_hit: got %0h want 0", bus.hit_o); end
    cycle();
    drive_idle();
  endtask

  task automatic test_lru_victim();
    drive_idle();
    bus.tag_i = tag_t'(8'h34);
    #1;
    n_cmp++; if (bus.victim_way_o !== way_idx_t'(1) || bus.victim_valid_o !== 1'b0) begin n_err++; $display("FAIL lru_pre_victim: way %0h valid %0h want 1 0", bus.victim_way_o, bus.victim_valid_o); end
    bus.refill_start_i = 1'b1;
    cycle();
    bus.refill_start_i = 1'b0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      bus.refill_valid_i = 1'b1;
      bus.refill_data_i  = 32'hB0 + 32'(i);
      cycle();
    end
    bus.refill_valid_i = 1'b0;
    bus.offset_i = word_idx_t'(1);
    #1;
    n_cmp++; if (bus.victim_way_o !== way_idx_t'(0)) begin n_err++; $display("FAIL lru_victim_after_fill: got %0h want 0", bus.victim_way_o); end
    n_cmp++; if (bus.victim_dirty_o !== 1'b1) begin n_err++; $display("FAIL lru_victim_dirty: got %0h want 1", bus.victim_dirty_o); end
    n_cmp++; if (bus.victim_data_o !== 32'h0000BEEF) begin n_err++; $display("FAIL lru_victim_data: got %08h want 0000beef", bus.victim_data_o); end
    bus.lookup_i = 1'b1;
    bus.tag_i = tag_t'(8'h12);
    cycle();
    bus.lookup_i = 1'b0;
    #1;
    n_cmp++; if (bus.victim_way_o !== way_idx_t'(1)) begin n_err++; $display("FAIL lru_victim_after_hit: got %0h want 1", bus.victim_way_o); end
    n_cmp++; if (bus.victim_tag_o !== tag_t'(8'h34)) begin n_err++; $display("FAIL lru_victim_tag: got %0h want 34", bus.victim_tag_o); end
    n_cmp++; if (bus.victim_dirty_o !== 1'b0 || bus.victim_valid_o !== 1'b1) begin n_err++; $display("FAIL lru_victim_flags: dirty %0h valid %0h want 0 1", bus.victim_dirty_o, bus.victim_valid_o); end
    drive_idle();
  endtask

  task automatic test_reset_mid_refill();
    drive_idle();
    bus.tag_i = tag_t'(8'h56);
    bus.refill_start_i = 1'b1;
    cycle();
    bus.refill_start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.refill_valid_i = 1'b1;
      bus.refill_data_i  = 32'hC0 + 32'(i);
      cycle();
    end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %0h want 1", bus.busy_o); end
    rst_n = 1'b0;
    bus.refill_valid_i = 1'b0;
    bus.lookup_i = 1'b1;
    bus.tag_i = tag_t'(8'h12);
    #1;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0h want 0", bus.busy_o); end
    n_cmp++; if (bus.hit_o !== 1'b0) begin n_err++; $display("FAIL midrst_hit: got %0h want 0", bus.hit_o); end
    n_cmp++; if (bus.victim_way_o !== way_idx_t'(0) || bus.victim_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_victim: way %0h valid %0h want 0 0", bus.victim_way_o, bus.victim_valid_o); end
    for (int w = 0; w < WAYS; w++) begin
      n_cmp++; if (dut.age_q[w] !== age_t'(w)) begin n_err++; $display("FAIL midrst_age%0d: got %0h want %0h", w, dut.age_q[w], w); end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive_idle();
    cycle();
  endtask

  task automatic test_random();
    tag_t tags [4];
    int h, v;
    logic [31:0] exp_rd;
    tags[0] = tag_t'(8'h12);
    tags[1] = tag_t'(8'h34);
    tags[2] = tag_t'(8'h56);
    tags[3] = tag_t'(8'h78);
    for (int n = 0; n < 400; n++) begin
      bus.lookup_i       = ($urandom_range(0, 1) == 1);
      bus.tag_i          = tags[$urandom_range(0, 3)];
      bus.offset_i       = word_idx_t'($urandom);
      bus.write_en_i     = ($urandom_range(0, 3) == 0);
      bus.byte_en_i      = 4'($urandom);
      bus.write_data_i   = $urandom;
      bus.refill_start_i = ($urandom_range(0, 9) == 0);
      bus.refill_valid_i = m_refilling ? ($urandom_range(0, 4) < 3) : ($urandom_range(0, 4) == 0);
      bus.refill_data_i  = $urandom;
      #1;
      h = model_hit();
      v = model_victim();
      exp_rd = (h >= 0) ? m_data[h][bus.offset_i] : 32'd0;
      n_cmp++; if (bus.hit_o !== (h >= 0)) begin n_err++; $display("FAIL rnd%0d_hit: got %0h want %0h", n, bus.hit_o, (h >= 0)); end
      n_cmp++; if (bus.hit_way_o !== way_idx_t'((h >= 0) ? h : 0)) begin n_err++; $display("FAIL rnd%0d_hit_way: got %0h want %0h", n, bus.hit_way_o, (h >= 0) ? h : 0); end
      n_cmp++; if (bus.read_data_o !== exp_rd) begin n_err++; $display("FAIL rnd%0d_read: got %08h want %08h", n, bus.read_data_o, exp_rd); end
      n_cmp++; if (bus.victim_way_o !== way_idx_t'(v)) begin n_err++; $display("FAIL rnd%0d_victim_way: got %0h want %0h", n, bus.victim_way_o, v); end
      n_cmp++; if (bus.victim_valid_o !== m_valid[v] || bus.victim_dirty_o !== m_dirty[v]) begin n_err++; $display("FAIL rnd%0d_victim_flags: got %0h%0h want %0h%0h", n, bus.victim_valid_o, bus.victim_dirty_o, m_valid[v], m_dirty[v]); end
      n_cmp++; if (bus.victim_tag_o !== m_tag[v]) begin n_err++; $display("FAIL rnd%0d_victim_tag: got %0h want %0h", n, bus.victim_tag_o, m_tag[v]); end
      n_cmp++; if (bus.victim_data_o !== m_data[v][bus.offset_i]) begin n_err++; $display("FAIL rnd%0d_victim_data: got %08h want %08h", n, bus.victim_data_o, m_data[v][bus.offset_i]); end
      cycle();
      n_cmp++; if (bus.busy_o !== m_refilling || bus.refill_done_o !== m_done) begin n_err++; $display("FAIL rnd%0d_busy_done: got %0h%0h want %0h%0h", n, bus.busy_o, bus.refill_done_o, m_refilling, m_done); end
    end
    drive_idle();
    while (m_refilling) begin
      bus.refill_valid_i = 1'b1;
      cycle();
    end
    drive_idle();
    cycle();
  endtask

`ifdef CACHE_SET_STATS_EN
  task automatic test_stats();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    n_cmp++; if (bus.hit_count_o !== 32'd0 || bus.miss_count_o !== 32'd0) begin n_err++; $display("FAIL stats_reset: got %0d %0d want 0 0", bus.hit_count_o, bus.miss_count_o); end
    bus.tag_i = tag_t'(8'h12);
    bus.refill_start_i = 1'b1;
    cycle();
    bus.refill_start_i = 1'b0;
    bus.lookup_i = 1'b1;
    bus.tag_i = tag_t'(8'h77);
    cycle();
    bus.lookup_i = 1'b0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      bus.refill_valid_i = 1'b1;
      cycle();
    end
    bus.refill_valid_i = 1'b0;
    n_cmp++; if (bus.miss_count_o !== 32'd0) begin n_err++; $display("FAIL stats_refill_miss: got %0d want 0", bus.miss_count_o); end
    bus.lookup_i = 1'b1;
    bus.tag_i = tag_t'(8'h12);
    repeat (3) cycle();
    bus.tag_i = tag_t'(8'h99);
    repeat (2) cycle();
    drive_idle();
    cycle();
    n_cmp++; if (bus.hit_count_o !== 32'd3) begin n_err++; $display("FAIL stats_hits: got %0d want 3", bus.hit_count_o); end
    n_cmp++; if (bus.miss_count_o !== 32'd2) begin n_err++; $display("FAIL stats_misses: got %0d want 2", bus.miss_count_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_refill();
    test_store();
    test_lru_victim();
    test_reset_mid_refill();
    test_random();
`ifdef CACHE_SET_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_set.md
Name: cache_set

Overview:
- One N-way set-associative cache set: per-way storage, tag compare, byte-enable writes, age-based LRU replacement, and a burst refill engine.
- Sits between the cache controller FSM and the per-index storage array; one instance per cache index.
- Replaces the single-line storage element; adds associativity, victim selection and multi-cycle refill.

Parameters:
- TAG_WIDTH, `CACHE_T, tag bits per way
- OFFSET_WIDTH, `CACHE_B, byte-offset bits; LINE_SIZE = 2**(OFFSET_WIDTH-2) words
- WAYS, 2, associativity; power of two, >= 2

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- lookup_i  in  1  access strobe; qualifies hit/miss for LRU and stats
- tag_i  in  TAG_WIDTH  lookup/write tag
- offset_i  in  OFFSET_WIDTH-2  word offset for read, write and victim read
- write_en_i  in  1  store request
- byte_en_i  in  4  byte lanes for store
- write_data_i  in  32  store data
- hit_o  out  1  comb: some valid way matches tag_i and state is IDLE
- hit_way_o  out  $clog2(WAYS)  comb: matching way index, 0 if no hit
- read_data_o  out  32  comb: hit way word at offset_i, 0 if no hit
- victim_way_o  out  $clog2(WAYS)  comb: way chosen for next refill
- victim_valid_o / victim_dirty_o  out  1  comb: victim way flags
- victim_tag_o  out  TAG_WIDTH  comb: victim tag, for writeback address
- victim_data_o  out  32  comb: victim word at offset_i, for writeback
- refill_start_i  in  1  begin refill of victim way with tag_i
- refill_valid_i  in  1  one refill word present
- refill_data_i  in  32  refill word
- busy_o  out  1  registered: high in REFILL
- refill_done_o  out  1  registered: one-cycle pulse after last word

Behaviour:
- Reset, asynchronous on rst_i low: all valid, dirty and tags 0; data 0; state IDLE; busy_o 0; refill_done_o 0; fill counter 0; age[w] = w.
- Victim selection: lowest-index invalid way; if all ways are valid, the way with age == WAYS-1.
- LRU touch of way w: every way with age < age[w] increments; age[w] <= 0. Ages stay a permutation of 0..WAYS-1.
- Touch events, at most one per cycle:
  - lookup_i && hit_o touches hit_way_o.
  - Refill completion touches the filled way.
- IDLE store: write_en_i && hit_o writes the byte_en_i lanes of the hit word at offset_i and sets dirty. Takes effect next edge. A store that misses is ignored; there is no write-allocate.
- IDLE to REFILL on refill_start_i:
  - Latch victim_way_o as fill way and tag_i as fill tag.
  - Clear the fill way's valid and dirty.
  - Reset the fill counter to 0.
- REFILL:
  - Each refill_valid_i writes refill_data_i to word [counter] of the fill way; counter increments.
  - hit_o is forced 0, write_en_i is ignored, and refill_start_i is ignored.
  - On the word where counter == LINE_SIZE-1: next edge sets valid=1, dirty=0, tag=fill tag; touches the way; pulses refill_done_o; returns to IDLE. busy_o falls the same edge.
- Latency: refill takes LINE_SIZE accepted words plus 0 extra cycles. refill_valid_i gaps are allowed; the counter holds.
- refill_valid_i in IDLE is ignored.
- Reset during REFILL aborts: IDLE, all ways invalid.
- Simultaneous store hit and refill_start_i in IDLE: the store writes first (same edge); the refill still starts. If the victim is the hit way, the dirty set is overridden by the clear.

Optional Feature:
- Macro CACHE_SET_STATS_EN.
- Defined:
  - Adds outputs hit_count_o[31:0] and miss_count_o[31:0].
  - Registered, reset to 0, saturating at 32'hFFFF_FFFF.
  - Hit counts lookup_i && hit_o; miss counts lookup_i && !hit_o && state IDLE.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- cache_pkg holds:
  - typedef enum logic {IDLE, REFILL} set_state_t
  - localparam LINE_SIZE
  - the way-index and age typedefs derived from WAYS
- One sub-module, cache_way, per way:
  - storage for valid, dirty, tag and data words
  - byte-enable write port, refill write port, set/clear flag inputs
  - comb tag match and word read
- cache_set instantiates WAYS copies via generate and owns the LRU ages, victim selection, FSM and stats.

Test Plan:
- Reset, then lookup tag 0x12 offset 0 -> hit_o=0, victim_way_o=0, victim_valid_o=0, busy_o=0.
- refill_start_i tag 0x12, then LINE_SIZE words 0xA0+i with one idle gap -> busy_o high throughout, refill_done_o pulses once. Lookup tag 0x12 offset 2 -> hit_o=1, read_data_o=0xA2, way 0.
- Store tag 0x12 offset 1, byte_en 4'b0011, data 0xDEADBEEF -> next read 0x0000BEEF; victim dirty flag for way 0 becomes 1.
- WAYS=2: fill tags 0x12 then 0x34, lookup 0x12, then refill_start_i -> victim_way_o=1 (0x34 is LRU). Writeback reads victim_tag_o=0x34.
- Assert rst_i low mid-refill after 2 words -> busy_o=0 immediately, hit_o=0 for 0x12, ages back to {0,1}.
- With CACHE_SET_STATS_EN: 3 hits and 2 misses -> hit_count_o=3, miss_count_o=2. Lookups during REFILL add no misses.
